dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_pkg.sv | 72 +++++++
 rtl/dmem_bram.sv | 43 ++++
 rtl/dmem_lsu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
//==============================================================================
// Module      : dmem_pkg
// Description : Shared types and lane helpers for the data-memory load/store unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10,
        W_RSVD = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        RESP = 2'b10
    } state_e;

    // Select the addressed lane from a RAM word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input width_e      width,
        input logic [1:0]  off,
        input logic        sext
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (width)
            W_BYTE:  res = {{24{sext & b[7]}}, b};
            W_HALF:  res = {{16{sext & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] byte_enable(
        input width_e     width,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (width)
            W_BYTE:  be = 4'b0001 << off;
            W_HALF:  be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-aligned store data copied onto every lane it could land in.
    function automatic logic [31:0] replicate_wdata(
        input width_e      width,
        input logic [31:0] data
    );
        logic [31:0] res;
        case (width)
            W_BYTE:  res = {4{data[7:0]}};
            W_HALF:  res = {2{data[15:0]}};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bram.sv
//==============================================================================
// Module      : dmem_bram
// Description : Single-port byte-enabled RAM with one-cycle synchronous read.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_bram #(
    parameter int DEPTH_WORDS = 16384,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // No reset on purpose: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
//==============================================================================
// Module      : dmem_lsu
// Description : Load/store unit in front of a byte-enabled data RAM.
//               Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
//               accesses instead of silently aligning them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_width,
    input  logic              req_sign_ext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    state_e            r_state;
    state_e            w_state_nxt;
    width_e            w_width;
    logic [ADDR_W-1:0] w_widx;
    logic              w_oob;
    logic              w_err;
    logic [1:0]        w_off;
    logic              w_accept;
    logic              w_ram_en;
    logic [3:0]        w_ram_be;
    logic [31:0]       w_ram_wdata;
    logic [31:0]       w_ram_rdata;

    width_e            r_width;
    logic [1:0]        r_off;
    logic              r_sext;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;

    assign w_width = width_e'(req_width);
    assign w_widx  = {2'b00, req_addr[ADDR_W-1:2]};
    assign w_oob   = (w_widx >= ADDR_W'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_width == W_HALF) && req_addr[0]) ||
                        ((w_width == W_WORD) && (req_addr[1:0] != 2'b00));
    assign w_err      = (w_width == W_RSVD) || w_oob || w_misalign;
    assign w_off      = req_addr[1:0];
`else
    assign w_err = (w_width == W_RSVD) || w_oob;
    // Misaligned accesses are quietly aligned down to their natural boundary.
    always_comb begin
        w_off = req_addr[1:0];
        case (w_width)
            W_HALF:  w_off[0] = 1'b0;
            W_WORD:  w_off    = 2'b00;
            default: w_off    = req_addr[1:0];
        endcase
    end
`endif

    assign req_ready   = (r_state == IDLE) && rst_n;
    assign w_accept    = req_valid && req_ready;
    assign w_ram_en    = w_accept && !w_err;
    assign w_ram_be    = byte_enable(w_width, w_off);
    assign w_ram_wdata = replicate_wdata(w_width, req_wdata);

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (req_we),
        .i_be    (w_ram_be),
        .i_addr  (req_addr[AW+1:2]),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_err || req_we) ? RESP : READ;
                end
            end
            READ:    w_state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Lane selection for the pending load, frozen at acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_width <= W_WORD;
            r_off   <= 2'b00;
            r_sext  <= 1'b0;
        end else if (w_accept) begin
            r_width <= w_width;
            r_off   <= w_off;
            r_sext  <= req_sign_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && (w_err || req_we)) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= 32'h0;
                        r_resp_err   <= w_err;
                    end
                end
                READ: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= lane_extract(w_ram_rdata, r_width, r_off, r_sext);
                    r_resp_err   <= 1'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_resp_valid <= 1'b0;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

`default_nettype wire
